// File: rtl/time_adjust_ctrl_pkg.sv
// Shared clock-adjust package: edit FSM states and default field moduli/widths.
package time_adjust_ctrl_pkg;

  localparam int unsigned DEF_MIN_N  = 60;
  localparam int unsigned DEF_HOUR_N = 24;
  localparam int unsigned DEF_MW     = 6;
  localparam int unsigned DEF_HW     = 5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EDIT_MIN  = 2'd1,
    ST_EDIT_HOUR = 2'd2,
    ST_COMMIT    = 2'd3
  } adj_state_e;

endpackage

// File: rtl/time_adjust_ctrl_if.sv
// Button/time bus between the user-input front end and the time-adjust controller.
interface time_adjust_ctrl_if #(
  parameter int unsigned MW = 6,
  parameter int unsigned HW = 5
);
  logic          btn_mode;
  logic          btn_up;
  logic          btn_down;
  logic          btn_cancel;
  logic [MW-1:0] cur_min;
  logic [HW-1:0] cur_hour;
  logic [MW-1:0] min_adj;
  logic [HW-1:0] hour_adj;
  logic          min_ld;
  logic          hour_ld;
  logic          editing;
  logic          field_sel;

  modport master (
    output btn_mode, btn_up, btn_down, btn_cancel, cur_min, cur_hour,
    input  min_adj, hour_adj, min_ld, hour_ld, editing, field_sel
  );

  modport slave (
    input  btn_mode, btn_up, btn_down, btn_cancel, cur_min, cur_hour,
    output min_adj, hour_adj, min_ld, hour_ld, editing, field_sel
  );
endinterface

// File: rtl/time_adjust_ctrl_edge_detect.sv
// Registered rising-edge detector; stays disarmed for the first cycle after reset
// so a button already held high at release is not seen as a new press.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic armed_q, armed_d;
  logic prev_q,  prev_d;
  logic rise_q,  rise_d;

  always_comb begin
    armed_d = 1'b1;
    prev_d  = btn;
    rise_d  = armed_q & btn & ~prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;
endmodule

// File: rtl/time_adjust_ctrl.sv
// Time-setting controller: mode steps IDLE->minutes->hours->commit, up/down
// adjust a shadow copy with wrap, and a one-cycle load strobe writes it back.
module time_adjust_ctrl
  import time_adjust_ctrl_pkg::*;
#(
  parameter int unsigned MIN_N  = DEF_MIN_N,
  parameter int unsigned HOUR_N = DEF_HOUR_N,
  parameter int unsigned MW     = DEF_MW,
  parameter int unsigned HW     = DEF_HW
) (
  input  logic                clk,
  input  logic                reset,
  time_adjust_ctrl_if.slave   bus
);
  logic rise_mode, rise_up, rise_down, rise_cancel;

  edge_detect u_ed_mode   (.clk(clk), .reset(reset), .btn(bus.btn_mode),   .rise(rise_mode));
  edge_detect u_ed_up     (.clk(clk), .reset(reset), .btn(bus.btn_up),     .rise(rise_up));
  edge_detect u_ed_down   (.clk(clk), .reset(reset), .btn(bus.btn_down),   .rise(rise_down));
  edge_detect u_ed_cancel (.clk(clk), .reset(reset), .btn(bus.btn_cancel), .rise(rise_cancel));

  adj_state_e    state_q, state_d;
  logic [MW-1:0] min_adj_q, min_adj_d;
  logic [HW-1:0] hour_adj_q, hour_adj_d;
  logic          ld_q, ld_d;
  logic          editing_q, editing_d;
  logic          field_sel_q, field_sel_d;

  // Simultaneous up and down cancel each other out.
  logic          step_up_c, step_dn_c;
  logic [MW-1:0] min_inc_c, min_dec_c;
  logic [HW-1:0] hour_inc_c, hour_dec_c;

  assign step_up_c  = rise_up & ~rise_down;
  assign step_dn_c  = rise_down & ~rise_up;
  assign min_inc_c  = (min_adj_q == MW'(MIN_N - 1)) ? '0 : min_adj_q + MW'(1);
  assign min_dec_c  = (min_adj_q == '0) ? MW'(MIN_N - 1) : min_adj_q - MW'(1);
  assign hour_inc_c = (hour_adj_q == HW'(HOUR_N - 1)) ? '0 : hour_adj_q + HW'(1);
  assign hour_dec_c = (hour_adj_q == '0) ? HW'(HOUR_N - 1) : hour_adj_q - HW'(1);

  always_comb begin
    state_d    = state_q;
    min_adj_d  = min_adj_q;
    hour_adj_d = hour_adj_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rise_mode) begin
          state_d    = ST_EDIT_MIN;
          min_adj_d  = bus.cur_min;
          hour_adj_d = bus.cur_hour;
        end
      end
      ST_EDIT_MIN: begin
        if (rise_cancel)    state_d   = ST_IDLE;
        else if (rise_mode) state_d   = ST_EDIT_HOUR;
        else if (step_up_c) min_adj_d = min_inc_c;
        else if (step_dn_c) min_adj_d = min_dec_c;
      end
      ST_EDIT_HOUR: begin
        if (rise_cancel)    state_d    = ST_IDLE;
        else if (rise_mode) state_d    = ST_COMMIT;
        else if (step_up_c) hour_adj_d = hour_inc_c;
        else if (step_dn_c) hour_adj_d = hour_dec_c;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    ld_d        = (state_d == ST_COMMIT);
    editing_d   = (state_d == ST_EDIT_MIN) || (state_d == ST_EDIT_HOUR);
    field_sel_d = (state_d == ST_EDIT_HOUR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      min_adj_q   <= '0;
      hour_adj_q  <= '0;
      ld_q        <= 1'b0;
      editing_q   <= 1'b0;
      field_sel_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_adj_q   <= min_adj_d;
      hour_adj_q  <= hour_adj_d;
      ld_q        <= ld_d;
      editing_q   <= editing_d;
      field_sel_q <= field_sel_d;
    end
  end

  assign bus.min_adj   = min_adj_q;
  assign bus.hour_adj  = hour_adj_q;
  assign bus.min_ld    = ld_q;
  assign bus.hour_ld   = ld_q;
  assign bus.editing   = editing_q;
  assign bus.field_sel = field_sel_q;
endmodule

// File: tb/tb_time_adjust_ctrl.sv
// Directed bench for time_adjust_ctrl: edit sequences, wrap limits, cancel, reset and held buttons.
module tb_time_adjust_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   fails = 0;
  int   passed;
  int   min_ld_cnt = 0;
  int   hour_ld_cnt = 0;

  always #5 clk = ~clk;

  time_adjust_ctrl_if #(.MW(6), .HW(5)) bus ();

  time_adjust_ctrl #(.MIN_N(60), .HOUR_N(24), .MW(6), .HW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.min_ld === 1'b1)  min_ld_cnt++;
    if (bus.hour_ld === 1'b1) hour_ld_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One press: high for a cycle, then low; FSM has acted when this returns.
  task automatic press(input bit m, input bit u, input bit d, input bit c);
    bus.btn_mode = m; bus.btn_up = u; bus.btn_down = d; bus.btn_cancel = c;
    step(1);
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_cancel = 1'b0;
    step(1);
  endtask

  initial begin
    reset = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_cancel = 1'b0;
    bus.cur_min = 6'd34; bus.cur_hour = 5'd12;
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_min_adj",   32'(bus.min_adj),   0);
    check("rst_hour_adj",  32'(bus.hour_adj),  0);
    check("rst_ld",        32'({bus.min_ld, bus.hour_ld}), 0);
    check("rst_editing",   32'(bus.editing),   0);
    check("rst_field_sel", 32'(bus.field_sel), 0);

    // 12:34 -> mode, up x3, mode, down x2, mode -> load 10:37
    press(1, 0, 0, 0);
    check("s1_editing",  32'(bus.editing),   1);
    check("s1_field0",   32'(bus.field_sel), 0);
    check("s1_cap_min",  32'(bus.min_adj),   34);
    check("s1_cap_hour", 32'(bus.hour_adj),  12);
    repeat (3) press(0, 1, 0, 0);
    check("s1_min_37", 32'(bus.min_adj), 37);
    press(1, 0, 0, 0);
    check("s1_field1", 32'(bus.field_sel), 1);
    repeat (2) press(0, 0, 1, 0);
    check("s1_hour_10", 32'(bus.hour_adj), 10);
    check("s1_min_hold", 32'(bus.min_adj), 37);
    check("s1_no_ld_yet", 32'(min_ld_cnt + hour_ld_cnt), 0);
    bus.btn_mode = 1'b1;
    step(1);
    bus.btn_mode = 1'b0;
    step(1);
    check("s1_min_ld",   32'(bus.min_ld),   1);
    check("s1_hour_ld",  32'(bus.hour_ld),  1);
    check("s1_ld_min",   32'(bus.min_adj),  37);
    check("s1_ld_hour",  32'(bus.hour_adj), 10);
    check("s1_ld_noedit", 32'(bus.editing), 0);
    step(1);
    check("s1_ld_off",    32'(bus.min_ld),  0);
    check("s1_ld_pulses", 32'(min_ld_cnt),  1);
    check("s1_hld_pulses", 32'(hour_ld_cnt), 1);
    check("s1_idle_keep", 32'(bus.min_adj), 37);

    // Wrap limits at 23:59
    min_ld_cnt = 0; hour_ld_cnt = 0;
    bus.cur_min = 6'd59; bus.cur_hour = 5'd23;
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    check("wrap_min_up",   32'(bus.min_adj), 0);
    press(0, 0, 1, 0);
    check("wrap_min_down", 32'(bus.min_adj), 59);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    check("wrap_hour_up",   32'(bus.hour_adj), 0);
    press(0, 0, 1, 0);
    check("wrap_hour_down", 32'(bus.hour_adj), 23);
    check("wrap_min_untouched", 32'(bus.min_adj), 59);
    press(0, 0, 0, 1);
    check("wrap_cancel_idle", 32'(bus.editing), 0);

    // Simultaneous up+down, mode+up, then cancel in EDIT_HOUR
    bus.cur_min = 6'd10; bus.cur_hour = 5'd5;
    press(1, 0, 0, 0);
    press(0, 1, 1, 0);
    check("updown_same", 32'(bus.min_adj), 10);
    press(1, 1, 0, 0);
    check("modeup_field", 32'(bus.field_sel), 1);
    check("modeup_min",   32'(bus.min_adj),   10);
    check("modeup_hour",  32'(bus.hour_adj),  5);
    press(0, 1, 0, 0);
    check("hour_up_6", 32'(bus.hour_adj), 6);
    press(1, 0, 0, 1);
    check("cancel_editing", 32'(bus.editing),   0);
    check("cancel_field",   32'(bus.field_sel), 0);
    step(3);
    check("cancel_no_ld", 32'(min_ld_cnt + hour_ld_cnt), 0);
    check("cancel_hold_hour", 32'(bus.hour_adj), 6);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    check("idle_ignore_min",  32'(bus.min_adj), 10);
    check("idle_ignore_edit", 32'(bus.editing), 0);

    // Reset in EDIT_MIN with up and mode held through release
    bus.cur_min = 6'd40; bus.cur_hour = 5'd20;
    press(1, 0, 0, 0);
    check("pre_rst_editing", 32'(bus.editing), 1);
    bus.btn_up = 1'b1; bus.btn_mode = 1'b1;
    step(1);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(4);
    check("mid_rst_editing", 32'(bus.editing),  0);
    check("mid_rst_min",     32'(bus.min_adj),  0);
    check("mid_rst_hour",    32'(bus.hour_adj), 0);
    check("mid_rst_field",   32'(bus.field_sel), 0);
    check("mid_rst_no_ld",   32'(min_ld_cnt + hour_ld_cnt), 0);
    bus.btn_up = 1'b0; bus.btn_mode = 1'b0;
    step(2);

    // Held up for 100 cycles gives a single increment
    bus.cur_min = 6'd15; bus.cur_hour = 5'd0;
    press(1, 0, 0, 0);
    bus.btn_up = 1'b1;
    step(100);
    bus.btn_up = 1'b0;
    step(2);
    check("held_up_once", 32'(bus.min_adj), 16);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    check("hour0_down", 32'(bus.hour_adj), 23);
    press(0, 0, 0, 1);
    check("final_no_ld", 32'(min_ld_cnt + hour_ld_cnt), 0);

    passed = total - fails;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
